onchip_mem_arbiter: RTL
=======================

// Module: onchip_mem_arbiter
// PURPOSE
//  Shares the single-port 32-bit on-chip RAM (12000 words, 1-cycle read latency) between two
//  Avalon-MM masters: m0 (CPU data port) and m1 (actuator/verin control engine).
//  Sits between the masters and the RAM slave port. Provides per-cycle round-robin arbitration,
//  read-return routing, and out-of-range address protection.
// PARAMETERS
//  ADDR_W   14     word address width, shared by masters and RAM
//  DATA_W   32     data width; byteenable width is DATA_W/8
//  DEPTH    12000  implemented words; addresses >= DEPTH are out of range
// PORTS
//  clk                 in   1       single clock for the block and the RAM
//  reset               in   1       synchronous, active-high
//  m0_address          in   ADDR_W  master 0 word address (m1_* set identical)
//  m0_byteenable       in   4       master 0 byte lanes
//  m0_read / m0_write  in   1       master 0 request strobes
//  m0_writedata        in   DATA_W  master 0 write data
//  m0_waitrequest      out  1       high = request not accepted this cycle, hold it
//  m0_readdata         out  DATA_W  read return data
//  m0_readdatavalid    out  1       one-cycle pulse, qualifies m0_readdata
//  m0_addr_err         out  1       sticky: master 0 issued an out-of-range access
//  mem_address         out  ADDR_W  to RAM address
//  mem_byteenable      out  4       to RAM byteenable
//  mem_chipselect      out  1       to RAM chipselect
//  mem_write           out  1       to RAM write
//  mem_writedata       out  DATA_W  to RAM writedata
//  mem_clken           out  1       to RAM clken; tied high
//  mem_readdata        in   DATA_W  from RAM, valid 1 cycle after an accepted read
// BEHAVIOUR
//  - Reset: last_grant=1 (m0 wins first contest); rd_pend=0; both readdatavalid=0; both addr_err=0.
//    A read accepted in the cycle reset asserts is discarded; no readdatavalid follows.
//  - req_i = mi_read | mi_write. Exactly one grant per cycle, combinational from the req_i and last_grant.
//    A single requester wins immediately. Under contention, the winner is the master != last_grant.
//    last_grant updates only on a granted cycle.
//  - mi_waitrequest = req_i & ~grant_i (combinational). The losing master holds its signals; it wins next cycle.
//    Sustained contention therefore alternates m0,m1,m0,... at 1 access per cycle each 2 cycles.
//  - Granted in-range access: mem_chipselect=1 and mem_address/byteenable/writedata are muxed from the winner.
//    mem_write = winner write. With no grant, chipselect=0 and write=0.
//  - Read pipeline: register rd_pend{valid,owner,oor}. At cycle N+1 after a read is accepted at N:
//    mi_readdatavalid=1 for owner only; mi_readdata=mem_readdata, or 32'h0 if oor.
//    Back-to-back reads by alternating owners each return in order, 1 cycle latency.
//  - mi_readdata is don't-care when readdatavalid=0. It is driven 0 to ease checking.
//  - Out-of-range (address >= DEPTH) write: accepted (waitrequest low), chipselect held 0, RAM untouched.
//    Out-of-range read: accepted, returns 0 with readdatavalid.
//    Both cases set mi_addr_err; it clears only on reset.
//  - read & write together from one master is illegal. Write takes priority and the read is dropped
//    (no readdatavalid).
//  - Write to address X from m0 and a read of X from m1 contending: order follows the grant.
//    Read-during-write on the same cycle cannot occur (single port).
//  - FSM: 2-state last_grant (LAST_M0, LAST_M1) plus a 1-deep read-return stage. No multi-cycle holds.
// STRUCTURE
//  - Package mem_arb_pkg: ADDR_W, DATA_W, DEPTH constants; typedef master_id_t (1 bit: M0=0, M1=1);
//    typedef rd_pend_t {valid, owner, oor}.
//  - Sub-module rr_arb2: 2-requester round-robin (req[1:0], last_grant reg, grant[1:0] one-hot).
//  - The top module holds the request mux, range check, read-return stage and sticky error flags.
// TESTING
//  1 Reset: hold reset 3 cycles with both masters requesting. Required: no chipselect effects,
//    readdatavalid=0, addr_err=0. First cycle after reset, grant=m0.
//  2 m0 writes 32'hDEADBEEF to addr 5 (be=4'hF), then reads addr 5.
//    Required: m0_readdatavalid exactly 1 cycle after read acceptance, data 32'hDEADBEEF.
//  3 m0 and m1 both read continuously for 8 cycles.
//    Required: grants alternate m0,m1,...; each master gets 4 readdatavalid pulses.
//    No pulse is ever routed to the wrong master.
//  4 Byte lanes: m1 writes 32'h11223344 to addr 9, then writes 32'hAAxxxxxx with be=4'h8.
//    Required: read of addr 9 returns 32'hAA223344.
//  5 m1 reads addr 12000 and writes addr 16383. Required: no RAM write; read returns 32'h0 with valid.
//    m1_addr_err=1 and stays set; m0_addr_err=0.
//  6 Reset asserted in the cycle after m0 read acceptance. Required: no m0_readdatavalid,
//    and arbitration restarts with m0 priority.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the on-chip RAM arbiter.
//   ADDR_W / DATA_W / BE_W : bus widths shared by both masters and the RAM
//   DEPTH                  : implemented RAM words; higher addresses are out of range
//   master_id_t            : master identifier (M0 = CPU data port, M1 = actuator engine)
//   arb_state_t            : round-robin memory of the last granted master
//   rd_pend_t              : one-deep read-return stage payload
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned DEPTH  = 12000;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  typedef enum logic {
    LAST_M0 = 1'b0,
    LAST_M1 = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic       valid;
    master_id_t owner;
    logic       oor;
  } rd_pend_t;

  // True when the word address maps onto implemented RAM.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (32'(addr) < DEPTH);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, reset   : clock, synchronous active-high reset (last grant -> M1)
//   req_i[1:0]   : request vector, bit i = master i
//   grant_c_o    : one-hot grant, combinational from req_i and the last grant
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] grant_c_o
);

  arb_state_t state_q, state_d;

  // Last-grant register; reset favours M0 in the first contest.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LAST_M1;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant selection and last-grant update (only on granted cycles).
  always_comb begin
    grant_c_o = 2'b00;
    state_d   = state_q;
    unique case (req_i)
      2'b01:   grant_c_o = 2'b01;
      2'b10:   grant_c_o = 2'b10;
      2'b11:   grant_c_o = (state_q == LAST_M1) ? 2'b01 : 2'b10;
      default: grant_c_o = 2'b00;
    endcase
    if (grant_c_o[0]) begin
      state_d = LAST_M0;
    end else if (grant_c_o[1]) begin
      state_d = LAST_M1;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-MM masters.
//   clk, reset              : single clock, synchronous active-high reset
//   m0_* / m1_*             : master ports (address, byteenable, read, write, writedata in;
//                             waitrequest, readdata, readdatavalid, sticky addr_err out)
//   mem_*                   : RAM slave port (address, byteenable, chipselect, write,
//                             writedata, clken out; readdata in, 1-cycle read latency)
// Per-cycle round-robin grant, in-order read-return routing, out-of-range protection.
module onchip_mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m0_addr_err,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              m1_addr_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0]        req_c;
  logic [1:0]        grant_c;
  logic              granted_c;
  master_id_t        win_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [BE_W-1:0]   win_be_c;
  logic              win_rd_c;
  logic              win_wr_c;
  logic [DATA_W-1:0] win_wd_c;
  logic              win_oor_c;
  logic              rd_accept_c;
  rd_pend_t          rd_pend_q, rd_pend_d;
  logic [1:0]        addr_err_q, addr_err_d;

  // Nothing is granted while reset is held, so no RAM access or read is accepted.
  assign req_c = {m1_read | m1_write, m0_read | m0_write} & {2{~reset}};

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_c),
    .grant_c_o (grant_c)
  );

  assign granted_c      = |grant_c;
  assign m0_waitrequest = (m0_read | m0_write) & ~grant_c[0];
  assign m1_waitrequest = (m1_read | m1_write) & ~grant_c[1];

  // Winner request mux.
  always_comb begin
    win_c      = grant_c[1] ? M1 : M0;
    win_addr_c = m0_address;
    win_be_c   = m0_byteenable;
    win_rd_c   = m0_read;
    win_wr_c   = m0_write;
    win_wd_c   = m0_writedata;
    if (win_c == M1) begin
      win_addr_c = m1_address;
      win_be_c   = m1_byteenable;
      win_rd_c   = m1_read;
      win_wr_c   = m1_write;
      win_wd_c   = m1_writedata;
    end
  end

  assign win_oor_c = ~in_range(win_addr_c);
  // Write wins over a simultaneous read; the read is dropped.
  assign rd_accept_c = granted_c & win_rd_c & ~win_wr_c;

  assign mem_clken      = 1'b1;
  assign mem_chipselect = granted_c & ~win_oor_c;
  assign mem_write      = granted_c & ~win_oor_c & win_wr_c;
  assign mem_address    = win_addr_c;
  assign mem_byteenable = win_be_c;
  assign mem_writedata  = win_wd_c;

  // Read-return stage and sticky error next state.
  always_comb begin
    rd_pend_d       = '0;
    rd_pend_d.valid = rd_accept_c;
    rd_pend_d.owner = win_c;
    rd_pend_d.oor   = win_oor_c;
    addr_err_d      = addr_err_q;
    if (granted_c && win_oor_c) begin
      addr_err_d[win_c] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= '0;
      addr_err_q <= 2'b00;
    end else begin
      rd_pend_q  <= rd_pend_d;
      addr_err_q <= addr_err_d;
    end
  end

  // A return pending when reset arrives is suppressed, not delivered.
  assign m0_readdatavalid = rd_pend_q.valid & (rd_pend_q.owner == M0) & ~reset;
  assign m1_readdatavalid = rd_pend_q.valid & (rd_pend_q.owner == M1) & ~reset;
  assign m0_readdata      = (m0_readdatavalid & ~rd_pend_q.oor) ? mem_readdata : '0;
  assign m1_readdata      = (m1_readdatavalid & ~rd_pend_q.oor) ? mem_readdata : '0;
  assign m0_addr_err      = addr_err_q[0];
  assign m1_addr_err      = addr_err_q[1];

endmodule
